// File: rtl/fpu_pkg.sv
// Shared binary32 definitions for the floating-point add/sub pipeline:
// field widths, special encodings and the per-stage payload structs.
package fpu_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 2 * BIAS + 1;   // all-ones exponent field (inf/NaN)
  localparam int SIG_W   = MAN_W + 4;      // hidden bit + mantissa + guard/round/sticky
  localparam int RD_W    = 5;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF   = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF   = 32'hFF80_0000;

  // S1 -> S2: operands ordered by magnitude, smaller one aligned with GRS
  typedef struct packed {
    logic             valid;
    logic [RD_W-1:0]  rd;
    logic             special;      // result fully decided in S1
    logic [31:0]      special_val;
    logic             sign;         // sign of the larger-magnitude operand
    logic [EXP_W-1:0] exp;          // exponent of the larger-magnitude operand
    logic             eff_sub;      // operand signs differ after applying FSUB
    logic [SIG_W-1:0] sig_l;
    logic [SIG_W-1:0] sig_s;
  } s1_t;

  // S2 -> S3: raw significand sum, one carry bit above the hidden bit
  typedef struct packed {
    logic             valid;
    logic [RD_W-1:0]  rd;
    logic             special;
    logic [31:0]      special_val;
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W:0]   sum;
  } s2_t;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == '1) && (x[22:0] != '0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == '1) && (x[22:0] == '0);
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter used by the normalization stage.
// An all-zero input returns W.
module fp_lzc #(
  parameter int W  = 27,
  parameter int CW = 5
) (
  input  logic [W-1:0]  i_data,
  output logic [CW-1:0] o_count
);

  // Scan upward so the highest set bit is the last one to win
  always_comb begin
    o_count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (i_data[i]) o_count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage binary32 FADD.S/FSUB.S unit with a dedicated write-back port.
// S1 unpack/order/align, S2 significand add/sub, S3 normalize/round/pack.
// Denormals are flushed to signed zero on input and output; RNE rounding.
module fp_add_pipe
  import fpu_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_sub,
  input  logic [RD_W-1:0] in_rd,
  input  logic [31:0]     in_a,
  input  logic [31:0]     in_b,
  input  logic            flush,
  output logic            float_wb_en,
  output logic [RD_W-1:0] float_wb_addr,
  output logic [31:0]     float_write_data,
  output logic            busy
);

  if (LATENCY != 3) begin : g_bad_latency
    $error("fp_add_pipe: only LATENCY=3 is supported");
  end

  // ---------------------------------------------------------------- S1
  logic             w_a_sign, w_b_sign;
  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic             w_a_zero, w_b_zero;
  logic             w_a_larger;
  logic [EXP_W-1:0] w_exp_l, w_exp_s, w_exp_diff;
  logic [MAN_W-1:0] w_man_l, w_man_s;
  logic [SIG_W-1:0] w_sig_s_full, w_lost_mask, w_sig_s_shift;
  logic [31:0]      w_b_eff;
  s1_t              w_s1;
  s1_t              r_s1;

  assign w_a_sign   = in_a[31];
  assign w_b_sign   = in_b[31] ^ in_sub;
  assign w_b_eff    = {w_b_sign, in_b[30:0]};
  assign w_a_exp    = in_a[30:23];
  assign w_b_exp    = in_b[30:23];
  // exponent 0 covers both true zero and denormals, which are flushed
  assign w_a_zero   = (w_a_exp == '0);
  assign w_b_zero   = (w_b_exp == '0);
  assign w_a_larger = (in_a[30:0] >= in_b[30:0]);

  assign w_exp_l    = w_a_larger ? w_a_exp : w_b_exp;
  assign w_exp_s    = w_a_larger ? w_b_exp : w_a_exp;
  assign w_man_l    = w_a_larger ? in_a[22:0] : in_b[22:0];
  assign w_man_s    = w_a_larger ? in_b[22:0] : in_a[22:0];
  assign w_exp_diff = w_exp_l - w_exp_s;

  // Align the smaller significand; everything shifted out collapses into sticky
  assign w_sig_s_full  = {1'b1, w_man_s, 3'b000};
  assign w_lost_mask   = ~({SIG_W{1'b1}} << w_exp_diff[4:0]);
  assign w_sig_s_shift = (w_sig_s_full >> w_exp_diff[4:0])
                       | {{(SIG_W-1){1'b0}}, |(w_sig_s_full & w_lost_mask)};

  // Build the S1 payload and resolve NaN/inf/zero operands up front
  always_comb begin
    // NOTE: every field gets a default before any branch, so no path can leave
    // a bit unassigned and infer a latch.
    w_s1          = '0;
    w_s1.valid    = in_valid & ~flush;
    w_s1.rd       = in_rd;
    w_s1.sign     = w_a_larger ? w_a_sign : w_b_sign;
    w_s1.exp      = w_exp_l;
    w_s1.eff_sub  = w_a_sign ^ w_b_sign;
    w_s1.sig_l    = {1'b1, w_man_l, 3'b000};
    w_s1.sig_s    = (w_exp_diff >= 8'(SIG_W)) ? {{(SIG_W-1){1'b0}}, 1'b1} : w_sig_s_shift;
    w_s1.special  = 1'b1;
    if (is_nan(in_a) || is_nan(in_b)) begin
      w_s1.special_val = CANON_NAN;
    end else if (is_inf(in_a) && is_inf(in_b)) begin
      w_s1.special_val = (w_a_sign != w_b_sign) ? CANON_NAN : in_a;
    end else if (is_inf(in_a)) begin
      w_s1.special_val = in_a;
    end else if (is_inf(in_b)) begin
      w_s1.special_val = w_b_eff;
    end else if (w_a_zero && w_b_zero) begin
      w_s1.special_val = {w_a_sign & w_b_sign, 31'd0};
    end else if (w_a_zero) begin
      w_s1.special_val = w_b_eff;
    end else if (w_b_zero) begin
      w_s1.special_val = in_a;
    end else begin
      w_s1.special = 1'b0;
    end
  end

  // S1 register: flush or an idle input leaves the stage empty
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: stage payload is reset together with its valid bit; it is a handful
    // of flops, not a memory array, and keeps every output defined from reset.
    if (!rst) begin
      r_s1 <= '0;
    end else begin
      // NOTE: non-blocking assignment, so every stage samples pre-edge values
      // regardless of the order the always blocks are evaluated in.
      r_s1 <= w_s1;
    end
  end

  // ---------------------------------------------------------------- S2
  s2_t w_s2;
  s2_t r_s2;

  // Signed magnitude add: sig_l >= sig_s, so subtraction never goes negative
  always_comb begin
    w_s2             = '0;
    w_s2.valid       = r_s1.valid & ~flush;
    w_s2.rd          = r_s1.rd;
    w_s2.special     = r_s1.special;
    w_s2.special_val = r_s1.special_val;
    w_s2.sign        = r_s1.sign;
    w_s2.exp         = r_s1.exp;
    w_s2.sum         = r_s1.eff_sub ? ({1'b0, r_s1.sig_l} - {1'b0, r_s1.sig_s})
                                    : ({1'b0, r_s1.sig_l} + {1'b0, r_s1.sig_s});
  end

  // S2 register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_s2 <= '0;
    else      r_s2 <= w_s2;
  end

  // ---------------------------------------------------------------- S3
  logic [4:0]       w_lz;
  logic [SIG_W-1:0] w_norm;
  logic [9:0]       w_exp_n;
  logic             w_round_up;
  logic [30:0]      w_rounded;
  logic             w_uflow, w_oflow;
  logic [31:0]      w_result;

  fp_lzc #(.W(SIG_W), .CW(5)) u_lzc (
    .i_data  (r_s2.sum[SIG_W-1:0]),
    .o_count (w_lz)
  );

  // Normalize: a carry shifts right once (keeping sticky), otherwise shift left
  always_comb begin
    w_norm  = '0;
    w_exp_n = '0;
    if (r_s2.sum[SIG_W]) begin
      w_norm  = {r_s2.sum[SIG_W:2], r_s2.sum[1] | r_s2.sum[0]};
      w_exp_n = {2'b00, r_s2.exp} + 10'd1;
    end else begin
      w_norm  = r_s2.sum[SIG_W-1:0] << w_lz;
      w_exp_n = {2'b00, r_s2.exp} - {5'd0, w_lz};
    end
  end

  // Round to nearest even; a mantissa carry ripples into the exponent field
  assign w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
  assign w_rounded  = {w_exp_n[7:0], w_norm[SIG_W-2:3]} + {30'd0, w_round_up};
  assign w_uflow    = w_exp_n[9] || (w_exp_n == '0);
  assign w_oflow    = (!w_exp_n[9] && (w_exp_n >= 10'(EXP_MAX))) || (w_rounded[30:23] == '1);

  // Pack; the hidden bit is clear only when the sum cancelled exactly
  always_comb begin
    w_result = '0;
    if (r_s2.special)             w_result = r_s2.special_val;
    else if (!w_norm[SIG_W-1])    w_result = '0;
    else if (w_uflow)             w_result = {r_s2.sign, 31'd0};
    else if (w_oflow)             w_result = r_s2.sign ? NEG_INF : POS_INF;
    else                          w_result = {r_s2.sign, w_rounded};
  end

  // Write-back register: address/data hold their last value while idle
  logic            r_wb_en;
  logic [RD_W-1:0] r_wb_addr;
  logic [31:0]     r_wb_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      r_wb_en <= r_s2.valid & ~flush;
      if (r_s2.valid && !flush) begin
        r_wb_addr <= r_s2.rd;
        r_wb_data <= w_result;
      end
    end
  end

  assign float_wb_en      = r_wb_en;
  assign float_wb_addr    = r_wb_addr;
  assign float_write_data = r_wb_data;
  assign busy             = r_s1.valid | r_s2.valid | r_wb_en;

endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench for fp_add_pipe: stimulus pushes expected write-backs,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_fp_add_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_sub, flush;
  logic [4:0]  in_rd;
  logic [31:0] in_a, in_b;
  logic        float_wb_en;
  logic [4:0]  float_wb_addr;
  logic [31:0] float_write_data;
  logic        busy;

  fp_add_pipe #(.LATENCY(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_sub           (in_sub),
    .in_rd            (in_rd),
    .in_a             (in_a),
    .in_b             (in_b),
    .flush            (flush),
    .float_wb_en      (float_wb_en),
    .float_wb_addr    (float_wb_addr),
    .float_write_data (float_write_data),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Reference: exact sum as a wide integer in units of 2^-149, then RNE to 24 bits
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b_in, input logic sub);
    logic [31:0]  b;
    logic         sa, sb, sign;
    int           ea, eb, p, e, sh;
    logic [299:0] ma, mb, mag, kept, rem, half;
    b     = b_in;
    b[31] = b_in[31] ^ sub;
    sa = a[31];
    sb = b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC0_0000;
    if (ea == 255 && eb == 255) return (sa != sb) ? 32'h7FC0_0000 : a;
    if (ea == 255) return a;
    if (eb == 255) return b;
    ma = (ea == 0) ? '0 : (300'({1'b1, a[22:0]}) << (ea - 1));
    mb = (eb == 0) ? '0 : (300'({1'b1, b[22:0]}) << (eb - 1));
    if (sa == sb)      begin mag = ma + mb; sign = sa; end
    else if (ma >= mb) begin mag = ma - mb; sign = sa; end
    else               begin mag = mb - ma; sign = sb; end
    if (mag == 0) return {sa & sb, 31'd0};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - 22;
    if (e <= 0) return {sign, 31'd0};
    sh   = p - 23;
    kept = mag >> sh;
    rem  = mag - (kept << sh);
    if (sh > 0) begin
      half = 300'd1 << (sh - 1);
      if (rem > half || (rem == half && kept[0])) kept = kept + 1;
    end
    if (kept[24]) begin
      kept = kept >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {sign, 8'hFF, 23'd0};
    return {sign, 8'(e), kept[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] specials [8];
    int k;
    specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                 32'h7FC0_0001, 32'h0000_0123, 32'h807F_FFFF, 32'h7F7F_FFFF};
    k = $urandom_range(0, 9);
    if (k == 0) return specials[$urandom_range(0, 7)];
    if (k <= 2) return 32'($urandom);
    if (k == 3) return {1'($urandom), 8'($urandom_range(1, 4)), 23'($urandom)};
    if (k == 4) return {1'($urandom), 8'($urandom_range(250, 254)), 23'($urandom)};
    return {1'($urandom), 8'($urandom_range(118, 136)), 23'($urandom)};
  endfunction

  // Monitor: compare every write-back against the scoreboard; idle outputs must hold
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      last_addr = '0;
      last_data = '0;
    end else if (float_wb_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_wb: got addr=%0d data=%h, want no write-back", float_wb_addr, float_write_data);
        last_addr = float_wb_addr;
        last_data = float_write_data;
      end else begin
        e = exp_q.pop_front();
        check("wb_addr", {27'd0, float_wb_addr}, {27'd0, e.rd});
        check("wb_data", float_write_data, e.data);
        check("wb_cycle", 32'(cyc), 32'(e.due));
        last_addr = e.rd;
        last_data = e.data;
      end
    end else begin
      check("hold_addr", {27'd0, float_wb_addr}, {27'd0, last_addr});
      check("hold_data", float_write_data, last_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic sub, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_sub   = sub;
    in_rd    = rd;
    in_a     = a;
    in_b     = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_expect(input logic sub, input logic [4:0] rd, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] req);
    exp_t e;
    e.rd   = rd;
    e.data = req;
    e.due  = cyc + 3;
    exp_q.push_back(e);
    issue(sub, rd, a, b);
  endtask

  task automatic send_model(input logic sub, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    send_expect(sub, rd, a, b, ref_add(a, b, sub));
  endtask

  task automatic drain();
    int budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    rst = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_rd = '0;
    in_a = '0; in_b = '0; flush = 1'b0;
    #1;
    check("reset_wb_en", {31'd0, float_wb_en}, 32'd0);
    check("reset_addr",  {27'd0, float_wb_addr}, 32'd0);
    check("reset_data",  float_write_data, 32'd0);
    check("reset_busy",  {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    step();

    // Basic latency and result
    send_expect(1'b0, 5'd5, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
    drain();

    // Rounding ties and specials, issued back-to-back
    send_expect(1'b0, 5'd6, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
    send_expect(1'b0, 5'd7, 32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001);
    send_expect(1'b1, 5'd8, 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000);
    send_expect(1'b0, 5'd9, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
    send_expect(1'b1, 5'd0, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000);
    drain();

    // Three consecutive ops rd=1,2,3 must write back on consecutive cycles
    send_expect(1'b0, 5'd1, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
    send_expect(1'b1, 5'd2, 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000);
    send_expect(1'b0, 5'd3, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    send_expect(1'b0, 5'd4, 32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000);
    send_expect(1'b0, 5'd4, 32'hFF80_0000, 32'h7FC0_0001, 32'h7FC0_0000);
    drain();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Flush with two ops in flight plus a dropped input on the flush cycle
    issue(1'b0, 5'd10, 32'h4040_0000, 32'h3F80_0000);
    issue(1'b1, 5'd11, 32'h4040_0000, 32'h3F80_0000);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_rd    = 5'd12;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_busy",  {31'd0, busy}, 32'd0);
    check("flush_wb_en", {31'd0, float_wb_en}, 32'd0);
    repeat (4) step();
    send_expect(1'b0, 5'd13, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
    drain();

    // Reset one cycle after accept: outputs clear at once, no write-back later
    issue(1'b0, 5'd14, 32'h3F80_0000, 32'h3F80_0000);
    step();
    rst = 1'b0;
    #1;
    check("midrst_wb_en", {31'd0, float_wb_en}, 32'd0);
    check("midrst_addr",  {27'd0, float_wb_addr}, 32'd0);
    check("midrst_data",  float_write_data, 32'd0);
    check("midrst_busy",  {31'd0, busy}, 32'd0);
    step();
    step();
    rst = 1'b1;
    repeat (6) step();
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        step();
      end else begin
        a = rand_fp();
        if ($urandom_range(0, 3) == 0) b = a ^ (32'($urandom) & 32'h0000_01FF);
        else                           b = rand_fp();
        send_model(1'($urandom), 5'($urandom), a, b);
      end
    end
    drain();
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
